// File: rtl/full_adder_cell.sv
// Single-bit combinational full-adder cell; the ripple chain in full_adder
// is built from these.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {cout, sum} = a + b + cin, presented one clock
// after a valid input.
module full_adder #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder_cell u_cell (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i]),
            .sum (sum_d[i]),
            .cout(carry[i+1])
        );
    end

    // Result holds its last value while in_valid is low; only the valid flag drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_d;
                cout <= carry[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: a WIDTH=1 and a WIDTH=4 instance share clock and reset.
module tb_full_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0, v1 = 1'b0;
    logic       sum1, cout1, ov1;

    logic [3:0] a4 = 4'h0, b4 = 4'h0;
    logic       cin4 = 1'b0, v4 = 1'b0;
    logic [3:0] sum4;
    logic       cout4, ov4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a1),
        .b        (b1),
        .cin      (cin1),
        .in_valid (v1),
        .sum      (sum1),
        .cout     (cout1),
        .out_valid(ov1)
    );

    full_adder #(.WIDTH(4)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a4),
        .b        (b4),
        .cin      (cin4),
        .in_valid (v4),
        .sum      (sum4),
        .cout     (cout4),
        .out_valid(ov4)
    );

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({cout1, sum1, ov1} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_w1: got cout/sum/ov=%b%b%b want 000", cout1, sum1, ov1);
        end
        n_cmp++;
        if ({cout4, sum4, ov4} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_w4: got cout=%b sum=%h ov=%b want 0/0/0", cout4, sum4, ov4);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_exhaustive_w1();
        logic [1:0] exp_tab [8];
        logic [2:0] vec;
        exp_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vec = 3'(i);
            {a1, b1, cin1} = vec;
            v1 = 1'b1;
            @(negedge clk);
            v1 = 1'b0;
            n_cmp++;
            if ({cout1, sum1} !== exp_tab[i] || ov1 !== 1'b1) begin
                n_err++;
                $display("FAIL exhaustive_w1[%0d]: got cout,sum=%b%b ov=%b want %b ov=1",
                         i, cout1, sum1, ov1, exp_tab[i]);
            end
        end
    endtask

    task automatic run_w4(input string name, input logic [3:0] a, input logic [3:0] b,
                          input logic c, input logic [3:0] exp_sum, input logic exp_cout);
        @(negedge clk);
        a4 = a; b4 = b; cin4 = c; v4 = 1'b1;
        @(negedge clk);
        v4 = 1'b0;
        n_cmp++;
        if (sum4 !== exp_sum || cout4 !== exp_cout || ov4 !== 1'b1) begin
            n_err++;
            $display("FAIL %s: got sum=%h cout=%b ov=%b want sum=%h cout=%b ov=1",
                     name, sum4, cout4, ov4, exp_sum, exp_cout);
        end
    endtask

    task automatic test_boundaries_w4();
        run_w4("wrap_f_0_1", 4'hF, 4'h0, 1'b1, 4'h0, 1'b1);
        run_w4("all_ones_cin", 4'hF, 4'hF, 1'b1, 4'hF, 1'b1);
        run_w4("zero", 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        run_w4("mid_9_6_0", 4'h9, 4'h6, 1'b0, 4'hF, 1'b0);
        run_w4("mid_8_8_0", 4'h8, 4'h8, 1'b0, 4'h0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_prev;
        logic [4:0] exp_cur;
        for (int k = 0; k <= 200; k++) begin
            @(negedge clk);
            if (k > 0) begin
                n_cmp++;
                if ({cout4, sum4} !== exp_prev || ov4 !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b[%0d]: got %h ov=%b want %h ov=1",
                             k - 1, {cout4, sum4}, ov4, exp_prev);
                end
            end
            if (k < 200) begin
                a4 = 4'($urandom_range(15, 0));
                b4 = 4'($urandom_range(15, 0));
                cin4 = 1'($urandom_range(1, 0));
                v4 = 1'b1;
                exp_cur = 5'(a4) + 5'(b4) + 5'(cin4);
                exp_prev = exp_cur;
            end else begin
                v4 = 1'b0;
            end
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0; v1 = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({cout1, sum1, ov1} !== 3'b101) begin
            n_err++;
            $display("FAIL hold_load: got cout/sum/ov=%b%b%b want 101", cout1, sum1, ov1);
        end
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b1; cin1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({cout1, sum1, ov1} !== 3'b100) begin
                n_err++;
                $display("FAIL hold[%0d]: got cout/sum/ov=%b%b%b want 100", i, cout1, sum1, ov1);
            end
            a1 = ~a1; cin1 = ~cin1;
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; v1 = 1'b1;
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; v4 = 1'b1;
        @(posedge clk);
        #2;
        n_cmp++;
        if (ov1 !== 1'b1 || ov4 !== 1'b1) begin
            n_err++;
            $display("FAIL async_pre: got ov1=%b ov4=%b want 1/1", ov1, ov4);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cout1, sum1, ov1} !== 3'b000 || {cout4, sum4, ov4} !== 6'b0) begin
            n_err++;
            $display("FAIL async_clear: got w1=%b%b%b w4 cout=%b sum=%h ov=%b want all 0",
                     cout1, sum1, ov1, cout4, sum4, ov4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1; v1 = 1'b1;
        a4 = 4'h1; b4 = 4'h0; cin4 = 1'b1; v4 = 1'b1;
        @(negedge clk);
        v1 = 1'b0; v4 = 1'b0;
        n_cmp++;
        if ({cout1, sum1, ov1} !== 3'b101) begin
            n_err++;
            $display("FAIL async_after_w1: got cout/sum/ov=%b%b%b want 101", cout1, sum1, ov1);
        end
        n_cmp++;
        if (sum4 !== 4'h2 || cout4 !== 1'b0 || ov4 !== 1'b1) begin
            n_err++;
            $display("FAIL async_after_w4: got sum=%h cout=%b ov=%b want 2/0/1",
                     sum4, cout4, ov4);
        end
    endtask

    initial begin
        test_reset();
        test_exhaustive_w1();
        test_boundaries_w4();
        test_back_to_back();
        test_hold();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
